// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signal bundle for load_store_unit.
// Ports (all carried inside the interface):
//   req_*   : byte-addressed request from the MEM stage (valid/ready handshake)
//   resp_*  : one-cycle completion pulse with load data / error flag
//   mem_*   : word-addressed, zero-wait memory port
// Modports: slave = the load/store unit, master = core + memory side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 18
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer between the MEM stage and a word-addressed
// zero-wait memory. Converts one byte-addressed request into one or two word
// accesses (read-modify-write for byte/half stores), extracts big-endian load
// lanes with sign/zero extension, and rejects misaligned/out-of-range requests
// without touching memory.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : load_store_unit_if.slave (request, response and memory signals)
// Build option: define LSU_SUBWORD_EN to support byte/half accesses; without
// it only word accesses are legal and every other size returns an error.
module load_store_unit #(
    parameter int unsigned ADDR_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_AW = ADDR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                req_err_c;

`ifdef LSU_SUBWORD_EN
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [1:0]          off_q, off_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [4:0]          byte_sh_c;
    logic [4:0]          half_sh_c;
    logic [7:0]          lane_b_c;
    logic [15:0]         lane_h_c;
    logic [DATA_W-1:0]   mask_c;
    logic [DATA_W-1:0]   ins_c;
    logic [DATA_W-1:0]   load_data_c;
    logic [DATA_W-1:0]   merge_data_c;
`endif

    // Request legality: size/alignment plus upper byte-address bits
    always_comb begin
        req_err_c = (bus.req_addr >> BYTE_AW) != 32'd0;
`ifdef LSU_SUBWORD_EN
        case (bus.req_size)
            2'b00:   ;
            2'b01:   if (bus.req_addr[0]) req_err_c = 1'b1;
            2'b10:   if (bus.req_addr[1:0] != 2'b00) req_err_c = 1'b1;
            default: req_err_c = 1'b1;
        endcase
`else
        if (bus.req_size != 2'b10 || bus.req_addr[1:0] != 2'b00) req_err_c = 1'b1;
`endif
    end

`ifdef LSU_SUBWORD_EN
    // Big-endian lane select: byte offset 0 is bits [31:24], half offset 0 is [31:16]
    always_comb begin
        byte_sh_c = {~off_q, 3'b000};
        half_sh_c = {~off_q[1], 4'b0000};
        lane_b_c  = 8'(bus.mem_read_data >> byte_sh_c);
        lane_h_c  = 16'(bus.mem_read_data >> half_sh_c);
        case (size_q)
            2'b00:   load_data_c = signed_q ? {{24{lane_b_c[7]}}, lane_b_c} : {24'd0, lane_b_c};
            2'b01:   load_data_c = signed_q ? {{16{lane_h_c[15]}}, lane_h_c} : {16'd0, lane_h_c};
            default: load_data_c = bus.mem_read_data;
        endcase
        if (size_q == 2'b00) begin
            mask_c = 32'h0000_00FF << byte_sh_c;
            ins_c  = 32'(wdata_q[7:0]) << byte_sh_c;
        end else begin
            mask_c = 32'h0000_FFFF << half_sh_c;
            ins_c  = 32'(wdata_q) << half_sh_c;
        end
        merge_data_c = (bus.mem_read_data & ~mask_c) | ins_c;
    end
`endif

    // Next state and next registered outputs; strobes follow the next state
    always_comb begin
        state_d          = state_q;
        resp_rdata_d     = '0;
        resp_err_d       = 1'b0;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
`ifdef LSU_SUBWORD_EN
        write_d          = write_q;
        size_d           = size_q;
        signed_d         = signed_q;
        off_d            = off_q;
        wdata_d          = wdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    mem_address_d = bus.req_addr[ADDR_W+1:2];
`ifdef LSU_SUBWORD_EN
                    write_d  = bus.req_write;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    off_d    = bus.req_addr[1:0];
                    wdata_d  = bus.req_wdata[15:0];
`endif
                    if (req_err_c) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else if (bus.req_write && bus.req_size == 2'b10) begin
                        state_d          = S_WR;
                        mem_write_data_d = bus.req_wdata;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
`ifdef LSU_SUBWORD_EN
                if (write_q) begin
                    state_d          = S_WR;
                    mem_write_data_d = merge_data_c;
                end else begin
                    state_d      = S_RESP;
                    resp_rdata_d = load_data_c;
                end
`else
                state_d      = S_RESP;
                resp_rdata_d = bus.mem_read_data;
`endif
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        mem_read_d   = (state_d == S_RD);
        mem_write_d  = (state_d == S_WR);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_err_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
`ifdef LSU_SUBWORD_EN
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            off_q            <= 2'b00;
            wdata_q          <= '0;
`endif
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
`ifdef LSU_SUBWORD_EN
            write_q          <= write_d;
            size_q           <= size_d;
            signed_q         <= signed_d;
            off_q            <= off_d;
            wdata_q          <= wdata_d;
`endif
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model
// with a per-cycle expected-output schedule, a small word memory behind the
// unit, directed cases with literal expectations, then randomized traffic.
module tb_load_store_unit;
    localparam int unsigned ADDR_W = 18;

    typedef struct {
        bit                ready;
        bit                rd;
        bit                wr;
        bit                rv;
        bit                err;
        bit                zero;
        logic [31:0]       rdata;
        logic [31:0]       wdata;
        logic [ADDR_W-1:0] addr;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    bit   chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] ref_mem [0:1023];
    logic [31:0] dev_mem [0:1023];
    rec_t        exp_q [$];
    rec_t        cr;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Zero-wait memory device behind the unit
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) dev_mem[i] <= init_word(i);
        end else if (bus.mem_write) begin
            dev_mem[bus.mem_address[9:0]] <= bus.mem_write_data;
        end
    end

    always @(negedge clk) bus.mem_read_data <= dev_mem[bus.mem_address[9:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input bit ready, input bit rd, input bit wr, input bit rv);
        rec_t r;
        r.ready = ready; r.rd = rd; r.wr = wr; r.rv = rv;
        r.err = 1'b0; r.zero = 1'b0; r.rdata = '0; r.wdata = '0; r.addr = '0;
        return r;
    endfunction

    // Request-level reference: error, latency, load result and new word value
    function automatic void model(input bit w, input logic [1:0] sz, input bit sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output bit err, output int lat,
                                  output logic [31:0] rd, output logic [31:0] nw);
        longint unsigned lim = 64'd1 << (ADDR_W + 2);
        int          off = int'(a % 4);
        logic [31:0] old;
        logic [7:0]  b [4];
        logic [15:0] h;
        err = ({32'd0, a} >= lim) || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) ||
              (sz == 2'd2 && a % 4 != 0);
`ifndef LSU_SUBWORD_EN
        if (sz != 2'd2) err = 1'b1;
`endif
        old = ref_mem[(a / 4) % 1024];
        for (int i = 0; i < 4; i++) b[i] = old[31 - 8 * i -: 8];
        rd = '0;
        nw = old;
        if (err) begin
            lat = 1;
        end else if (!w) begin
            lat = 2;
            if (sz == 2'd0)      rd = sg ? 32'($signed(b[off])) : 32'(b[off]);
            else if (sz == 2'd1) begin
                h  = {b[off], b[off + 1]};
                rd = sg ? 32'($signed(h)) : 32'(h);
            end else rd = old;
        end else if (sz == 2'd2) begin
            lat = 2;
            nw  = wd;
        end else begin
            lat = 3;
            if (sz == 2'd0) b[off] = wd[7:0];
            else begin
                b[off] = wd[15:8];
                b[off + 1] = wd[7:0];
            end
            nw = {b[0], b[1], b[2], b[3]};
        end
    endfunction

    // Per-cycle compare against the expected schedule (idle when empty)
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cr = exp_q.pop_front();
            else                  cr = mk(1'b1, 1'b0, 1'b0, 1'b0);
            chk("req_ready",  32'(bus.req_ready),  32'(cr.ready));
            chk("mem_read",   32'(bus.mem_read),   32'(cr.rd));
            chk("mem_write",  32'(bus.mem_write),  32'(cr.wr));
            chk("resp_valid", 32'(bus.resp_valid), 32'(cr.rv));
            if (cr.rv || cr.ready) begin
                chk("resp_err",   32'(bus.resp_err), 32'(cr.err));
                chk("resp_rdata", bus.resp_rdata,    cr.rdata);
            end
            if (cr.rd || cr.wr) chk("mem_address", 32'(bus.mem_address), 32'(cr.addr));
            if (cr.wr)          chk("mem_write_data", bus.mem_write_data, cr.wdata);
            if (cr.zero) begin
                chk("rst_mem_address",    32'(bus.mem_address), 32'd0);
                chk("rst_mem_write_data", bus.mem_write_data,   32'd0);
            end
        end
    end

    task automatic drive_junk();
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_write  = 1'($urandom_range(0, 1));
        bus.req_size   = 2'($urandom_range(0, 3));
        bus.req_signed = 1'($urandom_range(0, 1));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    // Issue one request at a negedge while idle; returns at the negedge of the
    // idle cycle that follows the response.
    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output bit m_err, output logic [31:0] m_rd, output logic [31:0] m_nw);
        int   lat;
        rec_t r;
        logic [ADDR_W-1:0] ea = ADDR_W'(a >> 2);
        model(w, sz, sg, a, wd, m_err, lat, m_rd, m_nw);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        drive_junk();
        if (!m_err && (!w || sz != 2'd2)) begin
            r = mk(1'b0, 1'b1, 1'b0, 1'b0); r.addr = ea; exp_q.push_back(r);
        end
        if (!m_err && w) begin
            r = mk(1'b0, 1'b0, 1'b1, 1'b0); r.addr = ea; r.wdata = m_nw; exp_q.push_back(r);
            ref_mem[(a / 4) % 1024] = m_nw;
        end
        r = mk(1'b0, 1'b0, 1'b0, 1'b1); r.err = m_err; r.rdata = m_rd; exp_q.push_back(r);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        repeat (lat) begin
            @(negedge clk);
            drive_junk();
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Accept a request, then reset during its RD cycle
    task automatic do_abort(input bit w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        rec_t r;
        int   idx = int'((a / 4) % 1024);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_signed = 1'b0; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        r = mk(1'b0, 1'b1, 1'b0, 1'b0); r.addr = ADDR_W'(a >> 2); exp_q.push_back(r);
        r = mk(1'b1, 1'b0, 1'b0, 1'b0); r.zero = 1'b1; exp_q.push_back(r);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_mem_untouched", dev_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        bit          e;
        logic [31:0] rd, nw, a;
        logic [1:0]  sz;
        int          pick, bad;
        rst = 1'b1;
        mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        @(posedge clk);
        #1 mem_init = 1'b0;
        @(posedge clk);
        #1;
        begin
            rec_t r0;
            r0 = mk(1'b1, 1'b0, 1'b0, 1'b0);
            r0.zero = 1'b1;
            exp_q.push_back(r0);
        end
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-computed results
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, e, rd, nw);
        chk("pin_sw_err", 32'(e), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, e, rd, nw);
        chk("pin_lw_100", rd, 32'hDEAD_BEEF);
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_7F01, e, rd, nw);
`ifdef LSU_SUBWORD_EN
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, e, rd, nw);
        chk("pin_lb_101", rd, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, e, rd, nw);
        chk("pin_lbu_100", rd, 32'h0000_0080);
        do_req(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, e, rd, nw);
        chk("pin_lb_102", rd, 32'h0000_007F);
        do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, e, rd, nw);
        chk("pin_lh_100", rd, 32'hFFFF_80FF);
`else
        do_req(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, e, rd, nw);
        chk("pin_lb_err", 32'(e), 32'd1);
`endif
        do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h1122_3344, e, rd, nw);
`ifdef LSU_SUBWORD_EN
        do_req(1'b1, 2'd0, 1'b0, 32'h202, 32'h0000_00AB, e, rd, nw);
        chk("pin_sb_merge", nw, 32'h1122_AB44);
        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, e, rd, nw);
        chk("pin_lw_200", rd, 32'h1122_AB44);
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, e, rd, nw);
        chk("pin_lw_200", rd, 32'h1122_3344);
`endif
        do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, e, rd, nw);
        chk("pin_err_half", 32'(e), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, e, rd, nw);
        chk("pin_err_word", 32'(e), 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 32'h0010_0000, 32'h1234_5678, e, rd, nw);
        chk("pin_err_range", 32'(e), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, e, rd, nw);
        chk("pin_err_size", 32'(e), 32'd1);

`ifdef LSU_SUBWORD_EN
        do_abort(1'b1, 2'd0, 32'h201, 32'h0000_0055);
`else
        do_abort(1'b0, 2'd2, 32'h200, 32'h0);
`endif

        // Randomized traffic, mostly legal, with idle gaps
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            sz = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & ~32'd1;
                if (sz == 2'd2) a = a & ~32'd3;
            end
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(20, 31));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, e, rd, nw);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("schedule_drained", 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
        chk("final_memory_mismatches", 32'(bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
